// File: rtl/pipe_regx.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_regx
//  Purpose  : Elastic register pipeline of DEPTH WIDTH-bit stages. Each stage
//             carries a valid bit and uses a valid/ready handshake. Back-pressure
//             propagates stage by stage, and bubbles collapse toward the output.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_regx #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 2,
    parameter int              CNTW        = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             ivld,
    output logic             irdy,
    input  logic [WIDTH-1:0] idat,
    output logic             ovld,
    input  logic             ordy,
    output logic [WIDTH-1:0] odat,
    output logic [CNTW-1:0]  occ
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] dat     [DEPTH];
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [CNTW-1:0]  occ_nxt;

    // The consumer's ready enters at the tail of the ripple chain
    assign rdy[DEPTH] = ordy;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            // A stage is ready when it is empty or its successor is ready
            assign rdy[i] = ~vld[i] | rdy[i+1];

            if (i == 0) begin : g_head
                assign src_dat[i] = idat;
                assign src_vld[i] = ivld;
            end else begin : g_body
                assign src_dat[i] = dat[i-1];
                assign src_vld[i] = vld[i-1];
            end

            // Flush wins over any load; otherwise a ready stage takes its source
            assign vld_nxt[i] = flush ? 1'b0 : (rdy[i] ? src_vld[i] : vld[i]);

            // Stage valid register
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    vld[i] <= 1'b0;
                end else begin
                    vld[i] <= vld_nxt[i];
                end
            end

            // Stage data register; loads whenever the stage is ready, even on a bubble
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    dat[i] <= RESET_VALUE;
                end else if (!flush && rdy[i]) begin
                    dat[i] <= src_dat[i];
                end
            end
        end
    endgenerate

    // Popcount of the next-state valid vector feeds the occupancy register
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + CNTW'(vld_nxt[i]);
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ <= '0;
        end else begin
            occ <= occ_nxt;
        end
    end

    assign irdy = rdy[0] & ~flush;
    assign ovld = vld[DEPTH-1] & ~flush;
    assign odat = dat[DEPTH-1];

endmodule
`default_nettype wire
